// File: rtl/calc2_req_dispatcher.sv
// Request stage for calc2: takes one command at a time and issues it on one of
// four request ports as cmd+op1 then op2, allocating and freeing 2-bit tags per port.
module calc2_req_dispatcher #(
  parameter int NPORT = 4,
  parameter int NTAG  = 4
) (
  input  logic                 c_clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_port,
  input  logic [3:0]           in_cmd,
  input  logic [31:0]          in_op1,
  input  logic [31:0]          in_op2,
  output logic [1:0]           in_tag,
  output logic [4*NPORT-1:0]   req_cmd_out,
  output logic [32*NPORT-1:0]  req_data_out,
  output logic [2*NPORT-1:0]   req_tag_out,
  input  logic [2*NPORT-1:0]   resp_in,
  input  logic [2*NPORT-1:0]   tag_in,
  output logic [4:0]           in_flight,
  output logic [NPORT-1:0]     spurious_err
);

  typedef enum logic {
    IDLE = 1'b0,
    OP2  = 1'b1
  } phase_t;

  logic [NPORT*NTAG-1:0] busy_next_all;
  logic [NPORT-1:0]      in_op2_all;
  logic [NPORT-1:0]      full_all;
  logic [2*NPORT-1:0]    free_tag_all;
  logic [4:0]            in_flight_reg;
  logic [4:0]            in_flight_next;

  // Readiness looks only at the addressed port's registered state, never at in_valid.
  assign in_ready  = ~reset & ~in_op2_all[in_port] & ~full_all[in_port];
  assign in_tag    = free_tag_all[2*in_port +: 2];
  assign in_flight = in_flight_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NPORT; gi++) begin : g_port
      localparam logic [1:0] PORT_ID = 2'(gi);

      phase_t            phase_reg;
      logic [NTAG-1:0]   busy_reg;
      logic [NTAG-1:0]   busy_next;
      logic              spur_reg;
      logic              spur_next;
      logic [31:0]       op2_reg;
      logic [1:0]        tag_reg;
      logic [3:0]        cmd_out_reg;
      logic [31:0]       data_out_reg;
      logic [1:0]        tag_out_reg;
      logic [1:0]        free_tag;
      logic              accept;
      logic              done;
      logic [1:0]        done_tag;

      assign accept   = in_valid & in_ready & (in_port == PORT_ID);
      assign done     = |resp_in[2*gi +: 2];
      assign done_tag = tag_in[2*gi +: 2];

      // Lowest-numbered free tag; stays 0 when the port is full.
      always_comb begin
        free_tag = 2'd0;
        for (int t = NTAG - 1; t >= 0; t--) begin
          if (!busy_reg[t]) free_tag = 2'(t);
        end
      end

      // Completion is judged against the pre-edge state, so a same-edge accept
      // never masks or satisfies a response.
      always_comb begin
        busy_next = busy_reg;
        spur_next = spur_reg;
        if (done) begin
          if (busy_reg[done_tag]) busy_next[done_tag] = 1'b0;
          else                    spur_next = 1'b1;
        end
        if (accept) busy_next[free_tag] = 1'b1;
      end

      always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
          phase_reg    <= IDLE;
          busy_reg     <= '0;
          spur_reg     <= 1'b0;
          op2_reg      <= '0;
          tag_reg      <= '0;
          cmd_out_reg  <= '0;
          data_out_reg <= '0;
          tag_out_reg  <= '0;
        end else begin
          busy_reg <= busy_next;
          spur_reg <= spur_next;
          if (accept) begin
            phase_reg    <= OP2;
            op2_reg      <= in_op2;
            tag_reg      <= free_tag;
            cmd_out_reg  <= in_cmd;
            data_out_reg <= in_op1;
            tag_out_reg  <= free_tag;
          end else if (phase_reg == OP2) begin
            phase_reg    <= IDLE;
            cmd_out_reg  <= 4'd0;
            data_out_reg <= op2_reg;
            tag_out_reg  <= tag_reg;
          end else begin
            cmd_out_reg  <= 4'd0;
            data_out_reg <= 32'd0;
            tag_out_reg  <= 2'd0;
          end
        end
      end

      assign in_op2_all[gi]               = (phase_reg == OP2);
      assign full_all[gi]                 = &busy_reg;
      assign free_tag_all[2*gi +: 2]      = free_tag;
      assign busy_next_all[NTAG*gi +: NTAG] = busy_next;
      assign spurious_err[gi]             = spur_reg;
      assign req_cmd_out[4*gi +: 4]       = cmd_out_reg;
      assign req_data_out[32*gi +: 32]    = data_out_reg;
      assign req_tag_out[2*gi +: 2]       = tag_out_reg;
    end
  endgenerate

  // Outstanding count tracks busy exactly by counting the value busy is about to take.
  always_comb begin
    in_flight_next = 5'd0;
    for (int i = 0; i < NPORT*NTAG; i++) begin
      in_flight_next = in_flight_next + 5'(busy_next_all[i]);
    end
  end

  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) in_flight_reg <= 5'd0;
    else       in_flight_reg <= in_flight_next;
  end

endmodule

// File: tb/tb_calc2_req_dispatcher.sv
// Bench for calc2_req_dispatcher: table of per-cycle vectors plus hand sequences,
// with a queue of expected request beats checked every cycle.
module tb_calc2_req_dispatcher;

  logic         c_clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_port;
  logic [3:0]   in_cmd;
  logic [31:0]  in_op1;
  logic [31:0]  in_op2;
  logic [1:0]   in_tag;
  logic [15:0]  req_cmd_out;
  logic [127:0] req_data_out;
  logic [7:0]   req_tag_out;
  logic [7:0]   resp_in;
  logic [7:0]   tag_in;
  logic [4:0]   in_flight;
  logic [3:0]   spurious_err;

  calc2_req_dispatcher dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_port      (in_port),
    .in_cmd       (in_cmd),
    .in_op1       (in_op1),
    .in_op2       (in_op2),
    .in_tag       (in_tag),
    .req_cmd_out  (req_cmd_out),
    .req_data_out (req_data_out),
    .req_tag_out  (req_tag_out),
    .resp_in      (resp_in),
    .tag_in       (tag_in),
    .in_flight    (in_flight),
    .spurious_err (spurious_err)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  typedef struct {
    logic        valid;
    logic [1:0]  port;
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [7:0]  resp;
    logic [7:0]  tin;
    int          rdy;   // -1: not checked
    int          tag;   // -1: not checked
    int          fl;    // -1: not checked
  } vec_t;

  typedef struct {
    int          cyc;
    int          port;
    logic [3:0]  cmd;
    logic [31:0] data;
    logic [1:0]  tag;
  } beat_t;

  beat_t sb[$];
  vec_t  tbl[24];
  int    cyc;
  int    n_vec;
  int    n_bad;

  function automatic vec_t mk(input bit valid, input int port, input int cmd,
                              input logic [31:0] op1, input logic [31:0] op2,
                              input logic [7:0] resp, input logic [7:0] tin,
                              input int rdy, input int tag, input int fl);
    vec_t v;
    v.valid = valid; v.port = 2'(port); v.cmd = 4'(cmd);
    v.op1 = op1; v.op2 = op2; v.resp = resp; v.tin = tin;
    v.rdy = rdy; v.tag = tag; v.fl = fl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_outputs();
    logic [15:0]  ec;
    logic [127:0] ed;
    logic [7:0]   et;
    ec = '0; ed = '0; et = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        ec[4*sb[i].port +: 4]  = sb[i].cmd;
        ed[32*sb[i].port +: 32] = sb[i].data;
        et[2*sb[i].port +: 2]  = sb[i].tag;
        sb.delete(i);
      end
    end
    chk("req_cmd_out", req_cmd_out, ec);
    chk("req_data_out", req_data_out, ed);
    chk("req_tag_out", req_tag_out, et);
  endtask

  // One clock: drive, check handshake signals, push expected beats, check outputs.
  task automatic run(input vec_t v);
    beat_t b;
    in_valid = v.valid; in_port = v.port; in_cmd = v.cmd;
    in_op1 = v.op1; in_op2 = v.op2; resp_in = v.resp; tag_in = v.tin;
    #1;
    if (v.rdy >= 0) chk("in_ready", in_ready, v.rdy);
    if (v.tag >= 0) chk("in_tag", in_tag, v.tag);
    @(posedge c_clk);
    cyc++;
    if (v.valid && v.rdy == 1) begin
      b.cyc = cyc;     b.port = v.port; b.cmd = v.cmd;  b.data = v.op1; b.tag = 2'(v.tag);
      sb.push_back(b);
      b.cyc = cyc + 1; b.cmd = 4'd0;    b.data = v.op2;
      sb.push_back(b);
    end
    @(negedge c_clk);
    in_valid = 1'b0; resp_in = '0; tag_in = '0;
    check_outputs();
    if (v.fl >= 0) chk("in_flight", in_flight, v.fl);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_cmd"}, req_cmd_out, '0);
    chk({name, "_data"}, req_data_out, '0);
    chk({name, "_tag"}, req_tag_out, '0);
    chk({name, "_ready"}, in_ready, '0);
    chk({name, "_flight"}, in_flight, '0);
    chk({name, "_spur"}, spurious_err, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_bad = 0; cyc = 0;
    reset = 1'b1; in_valid = 1'b0; in_port = '0; in_cmd = '0;
    in_op1 = '0; in_op2 = '0; resp_in = '0; tag_in = '0;

    // Single issue
    tbl[0]  = mk(1, 0, 1, 32'h5, 32'h7, 8'h00, 8'h00, 1, 0, 1);
    tbl[1]  = mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 0, -1, 1);
    tbl[2]  = mk(0, 0, 0, 0, 0, 8'h01, 8'h00, 1, 1, 0);
    // Tag exhaustion on port 2
    tbl[3]  = mk(1, 2, 2, 32'h100, 32'h200, 8'h00, 8'h00, 1, 0, 1);
    tbl[4]  = mk(0, 2, 0, 0, 0, 8'h00, 8'h00, 0, -1, 1);
    tbl[5]  = mk(1, 2, 2, 32'h101, 32'h201, 8'h00, 8'h00, 1, 1, 2);
    tbl[6]  = mk(0, 2, 0, 0, 0, 8'h00, 8'h00, 0, -1, 2);
    tbl[7]  = mk(1, 2, 2, 32'h102, 32'h202, 8'h00, 8'h00, 1, 2, 3);
    tbl[8]  = mk(0, 2, 0, 0, 0, 8'h00, 8'h00, 0, -1, 3);
    tbl[9]  = mk(1, 2, 2, 32'h103, 32'h203, 8'h00, 8'h00, 1, 3, 4);
    tbl[10] = mk(0, 2, 0, 0, 0, 8'h00, 8'h00, 0, -1, 4);
    tbl[11] = mk(0, 2, 0, 0, 0, 8'h00, 8'h00, 0, 0, 4);
    tbl[12] = mk(0, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 4);
    tbl[13] = mk(0, 2, 0, 0, 0, 8'h10, 8'h10, 0, 0, 3);
    tbl[14] = mk(1, 2, 9, 32'h104, 32'h204, 8'h00, 8'h00, 1, 1, 4);
    tbl[15] = mk(0, 2, 0, 0, 0, 8'h10, 8'h00, 0, -1, 3);
    tbl[16] = mk(0, 2, 0, 0, 0, 8'h20, 8'h10, 1, 0, 2);
    tbl[17] = mk(0, 2, 0, 0, 0, 8'h30, 8'h20, 1, 0, 1);
    tbl[18] = mk(0, 2, 0, 0, 0, 8'h10, 8'h30, 1, 0, 0);
    // Interleave across all ports
    tbl[19] = mk(1, 0, 3, 32'hA0, 32'hB0, 8'h00, 8'h00, 1, 0, 1);
    tbl[20] = mk(1, 1, 4, 32'hA1, 32'hB1, 8'h00, 8'h00, 1, 0, 2);
    tbl[21] = mk(1, 2, 5, 32'hA2, 32'hB2, 8'h00, 8'h00, 1, 0, 3);
    tbl[22] = mk(1, 3, 6, 32'hA3, 32'hB3, 8'h00, 8'h00, 1, 0, 4);
    // Simultaneous completion, resp codes 1,3,2,1 all tag 0
    tbl[23] = mk(0, 0, 0, 0, 0, 8'b01_10_11_01, 8'h00, 1, 1, 0);

    @(negedge c_clk);
    @(negedge c_clk);
    check_all_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 24; i++) run(tbl[i]);
    chk("spur_after_simul", spurious_err, 4'b0000);

    // Port 0 is not ready on the edge directly after its accept
    run(mk(1, 0, 2, 32'hC0, 32'hD0, 8'h00, 8'h00, 1, 0, 1));
    in_valid = 1'b0; in_port = 2'd0;
    #1;
    chk("ready_p0_after_accept", in_ready, 1'b0);
    run(mk(1, 1, 3, 32'hC1, 32'hD1, 8'h00, 8'h00, 1, 0, 2));
    run(mk(0, 0, 0, 0, 0, 8'h05, 8'h00, 1, 1, 0));

    // Spurious response on port 3, tag 2
    run(mk(0, 3, 0, 0, 0, 8'h40, 8'h80, 1, 0, 0));
    chk("spur_set", spurious_err, 4'b1000);
    run(mk(1, 3, 7, 32'hE3, 32'hF3, 8'h00, 8'h00, 1, 0, 1));
    run(mk(0, 3, 0, 0, 0, 8'h00, 8'h00, 0, -1, 1));
    chk("spur_sticky", spurious_err, 4'b1000);

    // Reset while port 1 waits for its op2 cycle
    run(mk(1, 1, 8, 32'h1234, 32'h5678, 8'h00, 8'h00, 1, 0, 2));
    reset = 1'b1;
    #1;
    check_all_zero("rst_async");
    sb.delete();
    @(posedge c_clk);
    cyc++;
    @(negedge c_clk);
    check_all_zero("rst_held");
    reset = 1'b0;
    run(mk(1, 1, 8, 32'h4321, 32'h8765, 8'h00, 8'h00, 1, 0, 1));
    run(mk(0, 1, 0, 0, 0, 8'h00, 8'h00, 0, -1, 1));
    chk("spur_after_reset", spurious_err, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
